// File: rtl/sndcmd_tx.sv
// sndcmd_tx: queues main-CPU sound command bytes in a 4-deep FIFO and
// presents them to the sound board as sndno plus a timed sndstart strobe.
//
// Parameters:
//   HOLD    - clk8M cycles sndstart stays high per command (4..255)
//   GAP     - clk8M cycles sndstart stays low after a command (1..255)
//   TIMEOUT - max clk8M cycles spent waiting for snd_ack (1..65535)
//
// Ports:
//   clk8M    in   clock, all state on its rising edge
//   reset_n  in   asynchronous active-low reset
//   cmd_we   in   one-cycle write strobe for cmd_di
//   cmd_di   in   [7:0] command byte from the main CPU
//   snd_ack  in   one-cycle pulse when the sound CPU reads its latch
//   ovf_clr  in   clears the ovf and tmo sticky flags
//   sndno    out  [7:0] command byte presented to the sound board
//   sndstart out  start strobe, sndno is valid on its rising edge
//   busy     out  FSM not idle or FIFO not empty
//   fifo_cnt out  [2:0] FIFO occupancy 0..4
//   ovf      out  sticky: a write was dropped
//   tmo      out  sticky: an ack wait ended by timeout
//
// Build option: define SNDCMD_ACK_EN to add the WAIT_ACK state with
// snd_ack handshake and TIMEOUT; otherwise snd_ack is ignored, tmo is 0.

module sndcmd_tx #(
    parameter int HOLD    = 8,
    parameter int GAP     = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk8M,
    input  logic       reset_n,
    input  logic       cmd_we,
    input  logic [7:0] cmd_di,
    input  logic       snd_ack,
    input  logic       ovf_clr,
    output logic [7:0] sndno,
    output logic       sndstart,
    output logic       busy,
    output logic [2:0] fifo_cnt,
    output logic       ovf,
    output logic       tmo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_WAIT_ACK,
        S_GAP
    } state_t;

    localparam logic [15:0] HOLD_M1 = 16'(HOLD - 1);
    localparam logic [15:0] GAP_M1  = 16'(GAP - 1);

    state_t      state, state_d;
    logic [15:0] tmr;
    logic        tmr_clr;
    logic        pop;
    logic        push;
    logic        drop;
    logic        full;
    logic [1:0]  wptr, rptr;
    logic [7:0]  mem [4];

    assign full = (fifo_cnt == 3'd4);
    // A write into a full FIFO still fits when the FSM pops that cycle.
    assign push = cmd_we && (!full || pop);
    assign drop = cmd_we && full && !pop;
    assign busy = (state != S_IDLE) || (fifo_cnt != 3'd0);

`ifdef SNDCMD_ACK_EN
    localparam logic [15:0] TMO_M1 = 16'(TIMEOUT - 1);
    logic ack_seen;
    logic tmo_set;
`else
    logic unused_ack;
    assign unused_ack = snd_ack;
`endif

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        tmr_clr = 1'b0;
`ifdef SNDCMD_ACK_EN
        tmo_set = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                tmr_clr = 1'b1;
                if (fifo_cnt != 3'd0) begin
                    pop     = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (tmr == HOLD_M1) begin
                    tmr_clr = 1'b1;
`ifdef SNDCMD_ACK_EN
                    state_d = S_WAIT_ACK;
`else
                    state_d = S_GAP;
`endif
                end
            end
            S_WAIT_ACK: begin
`ifdef SNDCMD_ACK_EN
                if (ack_seen || snd_ack) begin
                    tmr_clr = 1'b1;
                    state_d = S_GAP;
                end else if (tmr == TMO_M1) begin
                    tmr_clr = 1'b1;
                    tmo_set = 1'b1;
                    state_d = S_GAP;
                end
`else
                tmr_clr = 1'b1;
                state_d = S_GAP;
`endif
            end
            S_GAP: begin
                if (tmr == GAP_M1) begin
                    tmr_clr = 1'b1;
                    // Chain straight into the next command so the low
                    // phase is exactly GAP cycles when bytes are queued.
                    if (fifo_cnt != 3'd0) begin
                        pop     = 1'b1;
                        state_d = S_ASSERT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tmr      <= 16'd0;
            sndstart <= 1'b0;
            sndno    <= 8'd0;
            wptr     <= 2'd0;
            rptr     <= 2'd0;
            fifo_cnt <= 3'd0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_d;
            tmr      <= tmr_clr ? 16'd0 : tmr + 16'd1;
            // Delayed one cycle so sndno is settled before the strobe rises.
            sndstart <= (state == S_ASSERT);
            if (pop) begin
                sndno <= mem[rptr];
                rptr  <= rptr + 2'd1;
            end
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk8M) begin
        if (push) begin
            mem[wptr] <= cmd_di;
        end
    end

`ifdef SNDCMD_ACK_EN
    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            ack_seen <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            // An early ack during the strobe ends WAIT_ACK on entry.
            if (pop) begin
                ack_seen <= 1'b0;
            end else if (state == S_ASSERT && snd_ack) begin
                ack_seen <= 1'b1;
            end
            if (tmo_set) begin
                tmo <= 1'b1;
            end else if (ovf_clr) begin
                tmo <= 1'b0;
            end
        end
    end
`else
    assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_sndcmd_tx.sv
// tb_sndcmd_tx: scoreboard bench for sndcmd_tx.
// Expected bytes are queued at write time; a monitor checks each strobe.

module tb_sndcmd_tx;

    localparam int HOLD = 8;
    localparam int GAPC = 32;
    localparam int TMO  = 4096;
`ifdef SNDCMD_ACK_EN
    localparam int ACKX = 4;
    localparam int ACK_DEF = 1;
`else
    localparam int ACKX = 0;
    localparam int ACK_DEF = 0;
`endif

    logic       clk8M = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_di = 8'd0;
    logic       snd_ack = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] sndno;
    logic       sndstart;
    logic       busy;
    logic [2:0] fifo_cnt;
    logic       ovf;
    logic       tmo;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         rises[$];
    int         ack_mode = 0;
    logic       mon_prev = 1'b0;
    logic [7:0] mon_e;
    int         w;
    int         t;

    sndcmd_tx #(.HOLD(HOLD), .GAP(GAPC), .TIMEOUT(TMO)) dut (
        .clk8M(clk8M),
        .reset_n(reset_n),
        .cmd_we(cmd_we),
        .cmd_di(cmd_di),
        .snd_ack(snd_ack),
        .ovf_clr(ovf_clr),
        .sndno(sndno),
        .sndstart(sndstart),
        .busy(busy),
        .fifo_cnt(fifo_cnt),
        .ovf(ovf),
        .tmo(tmo)
    );

    always #5 clk8M = ~clk8M;

    always @(posedge clk8M) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: every rising sndstart consumes one expected byte.
    always @(negedge clk8M) begin
        if (sndstart && !mon_prev) begin
            rises.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_sndstart: got sndno %0h expected none (edge %0d)",
                         sndno, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sndno", int'(sndno), int'(mon_e));
            end
        end
        mon_prev = sndstart;
    end

    // Ack driver. 1: pulse sampled 3 edges after the fall,
    // 2: random pulses, 3: pulse during the strobe, 0: none.
    initial begin : ack_drv
        logic prev;
        logic cur;
        prev = 1'b0;
        forever begin
            @(negedge clk8M);
            cur = sndstart;
            if (ack_mode == 1 && prev && !cur) begin
                prev = cur;
                @(posedge clk8M);
                @(posedge clk8M);
                #1 snd_ack = 1'b1;
                @(posedge clk8M);
                #1 snd_ack = 1'b0;
            end else if (ack_mode == 3 && !prev && cur) begin
                prev = cur;
                @(posedge clk8M);
                #1 snd_ack = 1'b1;
                @(posedge clk8M);
                #1 snd_ack = 1'b0;
            end else if (ack_mode == 2) begin
                prev = cur;
                @(posedge clk8M);
                #1 snd_ack = ($urandom_range(0, 3) == 0);
            end else begin
                prev = cur;
                snd_ack = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk8M);
        #1;
    endtask

    task automatic step_to(input int e);
        while (cyc < e) step(1);
    endtask

    task automatic wr(input logic [7:0] b, input bit emit);
        cmd_we = 1'b1;
        cmd_di = b;
        if (emit) exp_q.push_back(b);
        step(1);
        cmd_we = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k;
        k = 0;
        while (rises.size() < n && k < budget) begin
            step(1);
            k++;
        end
        chk("rise_count", rises.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            step(1);
            k++;
        end
        chk("idle", int'(busy), 0);
    endtask

    function automatic int rise_at(input int i);
        return (rises.size() > i) ? rises[i] : -1;
    endfunction

    task automatic run_single(input logic [7:0] b);
        int ws;
        rises.delete();
        ws = cyc + 1;
        wr(b, 1'b1);
        step(1);
        chk("pre_rise_low", int'(sndstart), 0);
        step(1);
        chk("rise_high", int'(sndstart), 1);
        chk("sndno_val", int'(sndno), int'(b));
        step_to(ws + 1 + HOLD);
        chk("hold_last_high", int'(sndstart), 1);
        step(1);
        chk("hold_end_low", int'(sndstart), 0);
        chk("rise_edge", rise_at(0), ws + 2);
        step_to(ws + HOLD + GAPC + ACKX);
        chk("busy_in_gap", int'(busy), 1);
        step(1);
        chk("busy_after_gap", int'(busy), 0);
        chk("tmo_single", int'(tmo), 0);
    endtask

    initial begin
        step(3);
        chk("rst_sndstart", int'(sndstart), 0);
        chk("rst_fifo_cnt", int'(fifo_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_tmo", int'(tmo), 0);
        chk("rst_sndno", int'(sndno), 0);
        reset_n = 1'b1;
        step(2);
        ack_mode = ACK_DEF;

        run_single(8'h25);
`ifndef SNDCMD_ACK_EN
        ack_mode = 2;
`endif
        run_single(8'h5A);
        ack_mode = ACK_DEF;
        step(2);

        // Five writes from idle: the first pop overlaps the second write.
        rises.delete();
        for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1);
        chk("burst_cnt", int'(fifo_cnt), 4);
        chk("burst_ovf", int'(ovf), 0);
        wait_rises(5, 5 * (HOLD + GAPC + ACKX) + 20);
        for (int i = 1; i < 5; i++)
            chk("burst_spacing", rise_at(i) - rise_at(i - 1),
                HOLD + GAPC + ACKX);
        wait_idle(200);

        // Overflow: sixth write dropped, then clear racing a new drop.
        rises.delete();
        for (int i = 0; i < 5; i++) wr(8'h11 + 8'(i), 1'b1);
        wr(8'h16, 1'b0);
        chk("drop_cnt", int'(fifo_cnt), 4);
        chk("drop_ovf", int'(ovf), 1);
        cmd_we = 1'b1;
        cmd_di = 8'h17;
        ovf_clr = 1'b1;
        step(1);
        cmd_we = 1'b0;
        ovf_clr = 1'b0;
        chk("set_wins_ovf", int'(ovf), 1);
        chk("set_wins_cnt", int'(fifo_cnt), 4);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        wait_rises(5, 5 * (HOLD + GAPC + ACKX) + 20);
        wait_idle(200);

        // Reset during the strobe with three bytes still queued.
        rises.delete();
        wr(8'h31, 1'b1);
        wr(8'h32, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h34, 1'b0);
        chk("rq_cnt", int'(fifo_cnt), 3);
        step(1);
        chk("rq_strobe", int'(sndstart), 1);
        reset_n = 1'b0;
        #1;
        chk("rq_sndstart", int'(sndstart), 0);
        chk("rq_fifo_cnt", int'(fifo_cnt), 0);
        chk("rq_busy", int'(busy), 0);
        chk("rq_sndno", int'(sndno), 0);
        step(2);
        reset_n = 1'b1;
        step(100);
        chk("no_resume", rises.size(), 1);
        wr(8'h35, 1'b1);
        wait_rises(2, 20);
        wait_idle(200);

`ifdef SNDCMD_ACK_EN
        // No ack: each wait ends by timeout, queue keeps going.
        ack_mode = 0;
        rises.delete();
        w = cyc + 1;
        wr(8'hA1, 1'b1);
        wr(8'hA2, 1'b1);
        t = w + 1 + HOLD + TMO;
        step_to(t - 1);
        chk("tmo_before", int'(tmo), 0);
        step(1);
        chk("tmo_set", int'(tmo), 1);
        wait_rises(2, GAPC + 10);
        chk("tmo_next_rise", rise_at(1), t + GAPC + 1);
        wait_idle(TMO + HOLD + GAPC + 50);
        chk("tmo_sticky", int'(tmo), 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("tmo_cleared", int'(tmo), 0);

        // Ack arriving during the strobe is remembered.
        ack_mode = 3;
        rises.delete();
        wr(8'hB1, 1'b1);
        wr(8'hB2, 1'b1);
        wait_rises(2, 2 * (HOLD + GAPC) + 20);
        chk("early_ack_spacing", rise_at(1) - rise_at(0), HOLD + GAPC + 1);
        wait_idle(200);
        chk("early_ack_tmo", int'(tmo), 0);
        ack_mode = ACK_DEF;
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sndcmd_tx.md
SNDCMD_TX -- requirements
Module: sndcmd_tx

Interface
REQ-001 SHALL have parameter HOLD, default 8: clk8M cycles sndstart is held high per command (legal 4..255).
REQ-002 SHALL have parameter GAP, default 32: clk8M cycles sndstart is held low after each command before the next may start (legal 1..255).
REQ-003 SHALL have parameter TIMEOUT, default 4096: maximum clk8M cycles spent waiting for snd_ack (legal 1..65535).
REQ-004 clk8M  input  1  single clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_we  input  1  main-CPU write strobe to the sound command port (one cycle per write).
REQ-007 cmd_di  input  8  command byte written by the main CPU.
REQ-008 snd_ack  input  1  one-cycle pulse when the sound CPU reads its command latch.
REQ-009 ovf_clr  input  1  clears the overflow flag.
REQ-010 sndno  output  8  command byte presented to the sound board.
REQ-011 sndstart  output  1  start strobe; the sound board latches sndno on its rising edge.
REQ-012 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-013 fifo_cnt  output  3  FIFO occupancy, 0..4.
REQ-014 ovf  output  1  sticky: a write was dropped.
REQ-015 tmo  output  1  sticky: a wait ended by TIMEOUT; cleared by ovf_clr.

Function
REQ-016 SHALL buffer commands in a 4-entry FIFO, first-in first-out, pointers wrapping modulo 4.
REQ-017 cmd_we with fifo_cnt<4 SHALL store cmd_di; fifo_cnt updates on the next edge.
REQ-018 cmd_we with fifo_cnt=4 and no pop that cycle SHALL drop the byte and set ovf; with a pop that same cycle SHALL accept it, fifo_cnt stays 4.
REQ-019 FSM states SHALL be IDLE, ASSERT, WAIT_ACK, GAP.
REQ-020 IDLE with fifo_cnt>0: pop head into sndno, go ASSERT; sndstart high from the next cycle.
REQ-021 Write to empty FIFO at edge N: sndstart high from edge N+2 (2-cycle latency).
REQ-022 ASSERT: sndstart high exactly HOLD cycles, then low and go to WAIT_ACK (macro on) or GAP (macro off).
REQ-023 sndno SHALL remain stable from the pop until the next pop.
REQ-024 WAIT_ACK: on snd_ack go GAP; after TIMEOUT cycles without snd_ack set tmo and go GAP.
REQ-025 snd_ack seen during ASSERT SHALL be remembered and end WAIT_ACK on its first cycle.
REQ-026 snd_ack in IDLE or GAP SHALL be ignored.
REQ-027 GAP: sndstart low exactly GAP cycles, then IDLE.
REQ-028 ovf_clr SHALL clear ovf and tmo; a simultaneous set event SHALL win (flag stays 1).
REQ-029 Consecutive commands: rising edges of sndstart SHALL be at least HOLD+GAP cycles apart.

Reset
REQ-030 reset_n low SHALL immediately force: sndno=0, sndstart=0, busy=0, fifo_cnt=0, ovf=0, tmo=0, FSM=IDLE, FIFO pointers 0, timers 0.
REQ-031 Reset mid-command SHALL drop sndstart at once and discard all queued bytes; no command resumes after release.
REQ-032 First sndstart after release SHALL require a new cmd_we.

Configuration
REQ-033 Macro SNDCMD_ACK_EN SHALL enable the WAIT_ACK state and snd_ack/TIMEOUT logic.
REQ-034 Without SNDCMD_ACK_EN, ASSERT SHALL go directly to GAP, snd_ack SHALL be ignored, tmo SHALL be tied 0.

Verification
REQ-035 Reset, cmd_we with 8'h25 at edge 10 -> sndno=8'h25, sndstart high edges 12..19, low after; busy low after GAP end.
REQ-036 Five back-to-back writes 8'h01..8'h05 while idle -> fifo_cnt reaches 4, byte 8'h05 dropped unless a pop coincides, ovf per REQ-018; emitted order 01,02,03,04(,05).
REQ-037 Macro on, snd_ack 3 cycles after sndstart falls -> GAP starts next cycle; next sndstart rise exactly GAP+1 cycles later.
REQ-038 Macro on, no snd_ack -> tmo=1 after 4096 WAIT_ACK cycles, queue continues; ovf_clr pulse -> tmo=0.
REQ-039 reset_n low during ASSERT with 3 bytes queued -> sndstart=0, fifo_cnt=0 same cycle; no sndstart after release without a write.
REQ-040 Macro off, snd_ack pulses random -> timing identical to REQ-035, tmo stays 0.
